// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
// Shared definitions for the shift-register step sequencer:
//   seq_state_t     - sequencer FSM state (IDLE: manual steps, AUTO: timed steps)
//   STEP_COUNT_W    - width of the issued-step counter
//   STEP_COUNT_MAX  - saturation value of that counter
//   sat_inc()       - saturating increment used by the counter
package shift_seq_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    AUTO = 1'b1
  } seq_state_t;

  localparam int STEP_COUNT_W = 16;
  localparam logic [STEP_COUNT_W-1:0] STEP_COUNT_MAX = 16'hFFFF;

  function automatic logic [STEP_COUNT_W-1:0] sat_inc(input logic [STEP_COUNT_W-1:0] v);
    return (v == STEP_COUNT_MAX) ? v : v + STEP_COUNT_W'(1);
  endfunction

endpackage

// File: rtl/shift_step_sequencer_if.sv
// shift_step_sequencer_if
// Per-cycle control bundle from the sequencer to the 8-bit rotating shift register.
//   step_en     - one-cycle update strobe
//   par_load    - with step_en: 1 = parallel load, 0 = shift/rotate
//   rot_right   - with step_en: rotate direction (1 = right)
//   asr         - with step_en: arithmetic shift right (MSB replicated)
//   auto_active - sequencer is in timed (AUTO) mode
//   step_count  - number of shift steps issued (0 when counting is not built)
//   state_dbg   - current sequencer FSM state, for observation only
// Qualifier semantics: there is no back-pressure. step_en is the only valid
// strobe; the register must act in every cycle step_en is high, and
// par_load/rot_right/asr are meaningful only in those cycles (forced 0 otherwise).
// modport master: the sequencer (drives); modport slave: the register (observes).
interface shift_step_sequencer_if;
  import shift_seq_pkg::*;

  logic                    step_en;
  logic                    par_load;
  logic                    rot_right;
  logic                    asr;
  logic                    auto_active;
  logic [STEP_COUNT_W-1:0] step_count;
  seq_state_t              state_dbg;

  modport master (
    output step_en, par_load, rot_right, asr, auto_active, step_count, state_dbg
  );

  modport slave (
    input step_en, par_load, rot_right, asr, auto_active, step_count, state_dbg
  );

endinterface

// File: rtl/btn_conditioner.sv
// btn_conditioner
// Cleans one raw push-button: 2-flop synchroniser, debounce, rising-edge pulse.
//   clk, reset  - system clock, synchronous active-high reset
//   btn_raw     - asynchronous raw button level
//   press       - registered one-cycle pulse when the accepted level rises
// Parameter DEBOUNCE_CYCLES (>=1): consecutive cycles the synchronised value
// must differ from the accepted level before the accepted level follows it.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      level  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 != level) begin
        // The Nth consecutive differing sample flips the level; the pulse
        // is raised in the same edge so it lines up with the new level.
        if (cnt == CNT_LAST) begin
          level <= sync_2;
          cnt   <= '0;
          press <= sync_2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/shift_step_sequencer.sv
// shift_step_sequencer
// Control front-end for the 8-bit rotating shift register. Conditions the
// three raw buttons and issues one clean registered step per press (IDLE) or
// one step every max(period,1) cycles (AUTO).
//   clk, reset           - system clock, synchronous active-high reset
//   btn_load/step/auto   - raw asynchronous buttons
//   dir_right, asr_sel   - quasi-static switches, sampled when a step is decided
//   period               - AUTO step interval in cycles (0 behaves as 1)
//   ctl                  - master side of shift_step_sequencer_if (all registered)
// Optional feature macro SEQ_STEP_COUNT_EN: when defined, ctl.step_count counts
// shift steps (saturating, cleared by loads); otherwise it is tied to zero.
module shift_step_sequencer
  import shift_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PERIOD_W        = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                btn_load,
  input  logic                btn_step,
  input  logic                btn_auto,
  input  logic                dir_right,
  input  logic                asr_sel,
  input  logic [PERIOD_W-1:0] period,
  shift_step_sequencer_if.master ctl
);

  logic press_load;
  logic press_step;
  logic press_auto;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_load (
    .clk(clk), .reset(reset), .btn_raw(btn_load), .press(press_load)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_step (
    .clk(clk), .reset(reset), .btn_raw(btn_step), .press(press_step)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_auto (
    .clk(clk), .reset(reset), .btn_raw(btn_auto), .press(press_auto)
  );

  seq_state_t          state_q, state_d;
  logic [PERIOD_W-1:0] timer_q, timer_d;
  logic [PERIOD_W-1:0] term_last;
  logic                step_d;
  logic                load_d;

  logic step_en_q, par_load_q, rot_right_q, asr_q;

  // Terminal timer value; a zero period behaves as a period of one.
  assign term_last = (period == '0) ? '0 : period - PERIOD_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Arbitration order: load press, then auto toggle, then timer/step press.
  // Losing presses are dropped in that cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    step_d  = 1'b0;
    load_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_load) begin
          step_d = 1'b1;
          load_d = 1'b1;
        end else if (press_auto) begin
          state_d = AUTO;
          timer_d = '0;
        end else if (press_step) begin
          step_d = 1'b1;
        end
      end
      AUTO: begin
        if (press_load) begin
          step_d  = 1'b1;
          load_d  = 1'b1;
          timer_d = '0;
        end else if (press_auto) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q >= term_last) begin
          // '>=' so a period shrunk below the running timer wraps at once.
          step_d  = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + PERIOD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_en_q   <= 1'b0;
      par_load_q  <= 1'b0;
      rot_right_q <= 1'b0;
      asr_q       <= 1'b0;
    end else begin
      step_en_q   <= step_d;
      par_load_q  <= step_d & load_d;
      rot_right_q <= step_d & dir_right;
      asr_q       <= step_d & dir_right & asr_sel;
    end
  end

  assign ctl.step_en     = step_en_q;
  assign ctl.par_load    = par_load_q;
  assign ctl.rot_right   = rot_right_q;
  assign ctl.asr         = asr_q;
  assign ctl.auto_active = (state_q == AUTO);
  assign ctl.state_dbg   = state_q;

`ifdef SEQ_STEP_COUNT_EN
  logic [STEP_COUNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (step_d && load_d) begin
      count_q <= '0;
    end else if (step_d) begin
      count_q <= sat_inc(count_q);
    end
  end

  assign ctl.step_count = count_q;
`else
  assign ctl.step_count = '0;
`endif

endmodule

// File: tb/tb_shift_step_sequencer.sv
// tb_shift_step_sequencer
// Randomised plus directed bench for shift_step_sequencer (DEBOUNCE_CYCLES=4).
// A cycle-level behavioural model (raw-sample history, window-based debounce,
// priority arbitration, elapsed-cycle timer) predicts every registered output
// and pushes it into exp_q; each cycle the oldest entry is compared.
module tb_shift_step_sequencer;

  localparam int D  = 4;
  localparam int PW = 24;
  localparam int W  = 21;

  logic          clk;
  logic          reset;
  logic          btn_load, btn_step, btn_auto;
  logic          dir_right, asr_sel;
  logic [PW-1:0] period;

  shift_step_sequencer_if ctl_if ();

  shift_step_sequencer #(.DEBOUNCE_CYCLES(D), .PERIOD_W(PW)) dut (
    .clk(clk), .reset(reset),
    .btn_load(btn_load), .btn_step(btn_step), .btn_auto(btn_auto),
    .dir_right(dir_right), .asr_sel(asr_sel), .period(period),
    .ctl(ctl_if)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  int           cyc    = 0;
  int           step_log[$];
  logic [2:0]   attr_log[$];
  int           auto_rise = -1;
  logic         auto_prev = 1'b0;

  // behavioural model state
  logic [2:0]   raw_q[$];
  logic [2:0]   sync_q[$];
  logic [2:0]   m_level, m_pend;
  logic         m_auto;
  int           m_elapsed;
  logic [15:0]  m_count;

  // stimulus state
  logic          dr_s = 1'b0, as_s = 1'b0;
  logic [PW-1:0] per_s = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Model of one cycle; inputs are those applied during the cycle, the pushed
  // vector is what the outputs must show in the following cycle.
  task automatic model_cycle(input logic [2:0] raw, input logic dr, input logic as,
                             input logic [PW-1:0] per, input logic rst);
    logic [2:0] press, sync;
    logic       step, load, diff;
    int         term;
    if (rst) begin
      raw_q.delete();
      sync_q.delete();
      m_level = '0; m_pend = '0; m_auto = 1'b0; m_elapsed = 0; m_count = '0;
      exp_q.push_back('0);
      return;
    end
    press  = m_pend;
    m_pend = '0;
    // Synchronised value is the raw value from two cycles back.
    raw_q.push_back(raw);
    if (raw_q.size() > 8) void'(raw_q.pop_front());
    sync = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 3'b000;
    sync_q.push_back(sync);
    if (sync_q.size() > 8) void'(sync_q.pop_front());
    // Accept a new level once the last D samples all disagree with it.
    for (int b = 0; b < 3; b++) begin
      if (sync_q.size() >= D) begin
        diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (sync_q[sync_q.size()-1-k][b] == m_level[b]) diff = 1'b0;
        if (diff) begin
          m_level[b] = ~m_level[b];
          m_pend[b]  = m_level[b];
        end
      end
    end
    term = (per == 0) ? 1 : int'(per);
    step = 1'b0;
    load = 1'b0;
    if (press[0]) begin
      step = 1'b1; load = 1'b1;
      m_elapsed = 0;
    end else if (press[2]) begin
      m_auto = ~m_auto;
      m_elapsed = 0;
    end else if (m_auto) begin
      if (m_elapsed + 1 >= term) begin
        step = 1'b1;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
      end
    end else if (press[1]) begin
      step = 1'b1;
    end
`ifdef SEQ_STEP_COUNT_EN
    if (step && load) m_count = '0;
    else if (step && m_count != 16'hFFFF) m_count = m_count + 16'd1;
`endif
    exp_q.push_back({step, load, step & dr, step & dr & as, m_auto, m_count});
  endtask

  // driver: one clock cycle with given inputs, then compare
  task automatic run_cycle(input logic [2:0] raw, input logic rst);
    logic [W-1:0] e;
    btn_load  = raw[0];
    btn_step  = raw[1];
    btn_auto  = raw[2];
    dir_right = dr_s;
    asr_sel   = as_s;
    period    = per_s;
    reset     = rst;
    model_cycle(raw, dr_s, as_s, per_s, rst);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("step_en",     32'(ctl_if.step_en),     32'(e[20]));
    check_eq("par_load",    32'(ctl_if.par_load),    32'(e[19]));
    check_eq("rot_right",   32'(ctl_if.rot_right),   32'(e[18]));
    check_eq("asr",         32'(ctl_if.asr),         32'(e[17]));
    check_eq("auto_active", 32'(ctl_if.auto_active), 32'(e[16]));
    check_eq("step_count",  32'(ctl_if.step_count),  32'(e[15:0]));
    if (ctl_if.step_en === 1'b1) begin
      step_log.push_back(cyc + 1);
      attr_log.push_back({ctl_if.par_load, ctl_if.rot_right, ctl_if.asr});
    end
    if (ctl_if.auto_active === 1'b1 && !auto_prev) auto_rise = cyc + 1;
    auto_prev = (ctl_if.auto_active === 1'b1);
    cyc++;
  endtask

  task automatic hold(input logic [2:0] raw, input int n);
    for (int i = 0; i < n; i++) run_cycle(raw, 1'b0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) run_cycle(3'b000, 1'b1);
  endtask

  function automatic int last_gap();
    if (step_log.size() < 2) return -1;
    return step_log[step_log.size()-1] - step_log[step_log.size()-2];
  endfunction

  initial begin
    int          n0, t, lat;
    logic [2:0]  rnd_raw;
    int          hold_left[3];
    logic [31:0] exp_cnt;

    btn_load = 1'b0; btn_step = 1'b0; btn_auto = 1'b0;
    dir_right = 1'b0; asr_sel = 1'b0; period = '0; reset = 1'b1;

    per_s = 24'd5;
    do_reset(3);

    // short glitch is rejected
    n0 = step_log.size();
    hold(3'b010, 3);
    hold(3'b000, 10);
    check_eq("glitch_no_step", 32'(step_log.size() - n0), 32'd0);

    // held step press: one step, D+3 cycles after the rise
    n0 = step_log.size();
    t  = cyc;
    hold(3'b010, 10);
    hold(3'b000, 10);
    check_eq("step_once", 32'(step_log.size() - n0), 32'd1);
    lat = (step_log.size() > n0) ? step_log[n0] - t : -1;
    check_eq("step_latency", 32'(lat), 32'(D + 3));

    // load and step together: load wins, nothing queued
    n0 = step_log.size();
    hold(3'b011, 10);
    hold(3'b000, 10);
    check_eq("load_step_once", 32'(step_log.size() - n0), 32'd1);
    check_eq("load_wins_par", (attr_log.size() > n0) ? 32'(attr_log[n0]) : 32'hDEAD, 32'b100);

    // switch sampling
    dr_s = 1'b1; as_s = 1'b1;
    n0 = step_log.size();
    hold(3'b010, 6);
    hold(3'b000, 8);
    check_eq("asr_right", (attr_log.size() > n0) ? 32'(attr_log[n0]) : 32'hDEAD, 32'b011);
    dr_s = 1'b0;
    n0 = step_log.size();
    hold(3'b010, 6);
    hold(3'b000, 8);
    check_eq("asr_left", (attr_log.size() > n0) ? 32'(attr_log[n0]) : 32'hDEAD, 32'b000);
    as_s = 1'b0;

    // AUTO at period 5, then period 2
    n0 = step_log.size();
    hold(3'b100, 6);
    for (int i = 0; i < 40 && step_log.size() == n0; i++) run_cycle(3'b000, 1'b0);
    check_eq("auto_first", (step_log.size() > n0) ? 32'(step_log[n0] - auto_rise) : 32'hFFFF_FFFF, 32'd5);
    per_s = 24'd2;
    hold(3'b000, 12);
    check_eq("auto_gap_2", 32'(last_gap()), 32'd2);

    // period 0 behaves as 1, then leave AUTO
    per_s = '0;
    hold(3'b000, 6);
    check_eq("auto_gap_0", 32'(last_gap()), 32'd1);
    hold(3'b100, 6);
    n0 = step_log.size();
    hold(3'b000, 8);
    check_eq("auto_stop", 32'(step_log.size() - n0), 32'd0);
    check_eq("auto_off", 32'(ctl_if.auto_active), 32'd0);

    // step counting, load clears, reset mid-AUTO
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      hold(3'b010, 6);
      hold(3'b000, 6);
    end
`ifdef SEQ_STEP_COUNT_EN
    exp_cnt = 32'd3;
`else
    exp_cnt = 32'd0;
`endif
    check_eq("count_three", 32'(ctl_if.step_count), exp_cnt);
    hold(3'b001, 6);
    hold(3'b000, 6);
    check_eq("count_load_clr", 32'(ctl_if.step_count), 32'd0);
    per_s = 24'd3;
    hold(3'b100, 6);
    hold(3'b000, 10);
    run_cycle(3'b000, 1'b1);
    check_eq("rst_outputs", {26'd0, ctl_if.step_en, ctl_if.par_load, ctl_if.rot_right,
                             ctl_if.asr, ctl_if.auto_active, ctl_if.step_count != 16'd0}, 32'd0);

    // randomised phase
    hold_left[0] = 0; hold_left[1] = 0; hold_left[2] = 0;
    rnd_raw = 3'b000;
    for (int i = 0; i < 2500; i++) begin
      for (int b = 0; b < 3; b++) begin
        if (hold_left[b] == 0) begin
          rnd_raw[b]   = ($urandom_range(0, 2) == 0);
          hold_left[b] = $urandom_range(1, 10);
        end else begin
          hold_left[b]--;
        end
      end
      if ($urandom_range(0, 19) == 0) dr_s = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 19) == 0) as_s = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 49) == 0) per_s = PW'($urandom_range(0, 6));
      run_cycle(rnd_raw, $urandom_range(0, 399) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
